// File: rtl/bc_polinomio_if.sv
// Handshake and datapath-control bundle between bc_polinomio and its surroundings.
// Optional contagem signal exists only when BC_CONTA_AVALIACOES_EN is defined.
interface bc_polinomio_if;
  logic       start;
  logic [0:1] m0;
  logic [0:1] m1;
  logic [0:1] m2;
  logic       lx;
  logic       ls;
  logic       lh;
  logic       h;
  logic       ocupado;
  logic       pronto;
`ifdef BC_CONTA_AVALIACOES_EN
  logic [7:0] contagem;

  modport master (
    output start,
    input  m0, m1, m2, lx, ls, lh, h, ocupado, pronto, contagem
  );
  modport slave (
    input  start,
    output m0, m1, m2, lx, ls, lh, h, ocupado, pronto, contagem
  );
`else
  modport master (
    output start,
    input  m0, m1, m2, lx, ls, lh, h, ocupado, pronto
  );
  modport slave (
    input  start,
    output m0, m1, m2, lx, ls, lh, h, ocupado, pronto
  );
`endif
endinterface

// File: rtl/bc_polinomio.sv
// Control block sequencing the polynomial datapath: y = ((A*X)+B)*X+C (Horner).
// Optional evaluation counter (contagem) enabled by defining BC_CONTA_AVALIACOES_EN.
module bc_polinomio (
  input  logic          clk,
  input  logic          rst,
  bc_polinomio_if.slave bc
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadx = 3'd1,
    StMul1  = 3'd2,
    StAdd1  = 3'd3,
    StMul2  = 3'd4,
    StAdd2  = 3'd5,
    StDone  = 3'd6
  } state_t;

  state_t     r_state;
  logic [0:1] r_m0;
  logic [0:1] r_m1;
  logic [0:1] r_m2;
  logic       r_lx;
  logic       r_ls;
  logic       r_h;
  logic       r_ocupado;
  logic       r_pronto;

  // Outputs are registered alongside the state, so each one is set from the
  // state being entered and always matches the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_m0      <= 2'b00;
      r_m1      <= 2'b00;
      r_m2      <= 2'b00;
      r_lx      <= 1'b0;
      r_ls      <= 1'b0;
      r_h       <= 1'b0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      r_m0      <= 2'b00;
      r_m1      <= 2'b00;
      r_m2      <= 2'b00;
      r_lx      <= 1'b0;
      r_ls      <= 1'b0;
      r_h       <= 1'b0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bc.start) begin
            r_state   <= StLoadx;
            r_lx      <= 1'b1;
            r_ocupado <= 1'b1;
          end else begin
            r_state <= StIdle;
          end
        end
        StLoadx: begin
          r_state   <= StMul1;
          r_m0      <= 2'b00;
          r_m2      <= 2'b01;
          r_m1      <= 2'b00;
          r_h       <= 1'b1;
          r_ls      <= 1'b1;
          r_ocupado <= 1'b1;
        end
        StMul1: begin
          r_state   <= StAdd1;
          r_m2      <= 2'b10;
          r_m0      <= 2'b10;
          r_m1      <= 2'b01;
          r_ls      <= 1'b1;
          r_ocupado <= 1'b1;
        end
        StAdd1: begin
          r_state   <= StMul2;
          r_m2      <= 2'b10;
          r_m1      <= 2'b00;
          r_h       <= 1'b1;
          r_ls      <= 1'b1;
          r_ocupado <= 1'b1;
        end
        StMul2: begin
          r_state   <= StAdd2;
          r_m2      <= 2'b10;
          r_m0      <= 2'b11;
          r_m1      <= 2'b01;
          r_ls      <= 1'b1;
          r_ocupado <= 1'b1;
        end
        StAdd2: begin
          r_state   <= StDone;
          r_ocupado <= 1'b1;
          r_pronto  <= 1'b1;
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bc.m0      = r_m0;
  assign bc.m1      = r_m1;
  assign bc.m2      = r_m2;
  assign bc.lx      = r_lx;
  assign bc.ls      = r_ls;
  assign bc.lh      = 1'b0;
  assign bc.h       = r_h;
  assign bc.ocupado = r_ocupado;
  assign bc.pronto  = r_pronto;

`ifdef BC_CONTA_AVALIACOES_EN
  logic [7:0] r_contagem;

  // Counts at the end of each DONE cycle; wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_contagem <= 8'd0;
    end else if (r_state == StDone) begin
      r_contagem <= r_contagem + 8'd1;
    end
  end

  assign bc.contagem = r_contagem;
`endif

endmodule

// File: tb/tb_bc_polinomio.sv
// Bench: bc_polinomio driving a small behavioural model of the 16-bit datapath.
// Directed vectors with hand-computed results; contagem test needs BC_CONTA_AVALIACOES_EN.
module tb_bc_polinomio;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bc_polinomio_if bc ();

  bc_polinomio dut (
    .clk (clk),
    .rst (rst),
    .bc  (bc)
  );

  always #5 clk = ~clk;

  // Datapath model
  logic [15:0] a, b, c, xis;
  logic [15:0] r0, r1, r2;
  logic [15:0] mux0, opa, opb, ula;

  function automatic logic [15:0] sel(input logic [1:0] s, input logic [15:0] x0,
                                      input logic [15:0] mx, input logic [15:0] x1,
                                      input logic [15:0] x2);
    case (s)
      2'b00:   return x0;
      2'b01:   return mx;
      2'b10:   return x1;
      default: return x2;
    endcase
  endfunction

  always_comb begin
    case (bc.m0)
      2'b10:   mux0 = b;
      2'b11:   mux0 = c;
      default: mux0 = a;
    endcase
    opa = sel(bc.m2, r0, mux0, r1, r2);
    opb = sel(bc.m1, r0, mux0, r1, r2);
    ula = bc.h ? 16'(opa * opb) : 16'(opa + opb);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
    end else begin
      if (bc.lx) r0 <= xis;
      if (bc.ls) r1 <= ula;
      if (bc.lh) r2 <= ula;
    end
  end

  // {m0, m1, m2, lx, ls, lh, h, ocupado, pronto}
  logic [11:0] w_outs;
  assign w_outs = {bc.m0, bc.m1, bc.m2, bc.lx, bc.ls, bc.lh, bc.h, bc.ocupado, bc.pronto};

  logic [11:0] exp_tab [0:6];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic run_eval(input logic [15:0] va, input logic [15:0] vb, input logic [15:0] vc,
                          input logic [15:0] vx, output logic [15:0] res, output int lat);
    a = va; b = vb; c = vc; xis = vx;
    bc.start = 1'b1;
    @(posedge clk); #1;
    bc.start = 1'b0;
    lat = 1;
    while (!bc.pronto && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = r1;
    @(posedge clk); #1;
  endtask

  logic [15:0] res;
  int          lat;
  int          ocup;
  int          npr;

  initial begin
    exp_tab[0] = 12'b00_00_00_1_0_0_0_1_0;  // LOADX
    exp_tab[1] = 12'b00_00_01_0_1_0_1_1_0;  // MUL1
    exp_tab[2] = 12'b10_01_10_0_1_0_0_1_0;  // ADD1
    exp_tab[3] = 12'b00_00_10_0_1_0_1_1_0;  // MUL2
    exp_tab[4] = 12'b11_01_10_0_1_0_0_1_0;  // ADD2
    exp_tab[5] = 12'b00_00_00_0_0_0_0_1_1;  // DONE
    exp_tab[6] = 12'b00_00_00_0_0_0_0_0_0;  // IDLE

    bc.start = 1'b0;
    a = '0; b = '0; c = '0; xis = '0;

    #12;
    chk("reset_outs", 32'(w_outs), 32'd0);
`ifdef BC_CONTA_AVALIACOES_EN
    chk("reset_contagem", 32'(bc.contagem), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_start", 32'(bc.ocupado), 32'd0);

    // Basic evaluation with per-state output table
    a = 16'd2; b = 16'd3; c = 16'd4; xis = 16'd5;
    bc.start = 1'b1;
    @(posedge clk); #1;
    bc.start = 1'b0;
    ocup = 0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("state_outs_%0d", i), 32'(w_outs), 32'(exp_tab[i]));
      if (bc.ocupado) ocup++;
      if (i == 5) chk("result_69", 32'(r1), 32'd69);
      if (i < 6) begin
        @(posedge clk); #1;
      end
    end
    chk("ocupado_cycles", 32'(ocup), 32'd6);

    // start during DONE is ignored
    bc.start = 1'b1;
    @(posedge clk); #1;
    bc.start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("done_reached", 32'(bc.pronto), 32'd1);
    bc.start = 1'b1;
    @(posedge clk); #1;
    bc.start = 1'b0;
    chk("start_in_done_ignored", 32'(bc.ocupado), 32'd0);
    @(posedge clk); #1;
    chk("still_idle", 32'(bc.ocupado), 32'd0);

    // start held high: back-to-back evaluations 7 cycles apart
    a = 16'd1; b = 16'd0; c = 16'd1; xis = 16'd3;
    bc.start = 1'b1;
    npr = 0;
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      if (bc.pronto) begin
        chk($sformatf("b2b_edge_%0d", npr), 32'(i), 32'(5 + 7 * npr));
        chk($sformatf("b2b_result_%0d", npr), 32'(r1), 32'd10);
        npr++;
      end
    end
    bc.start = 1'b0;
    chk("b2b_pulses", 32'(npr), 32'd3);
    @(posedge clk); #1;

    // Reset during MUL2
    a = 16'd2; b = 16'd3; c = 16'd4; xis = 16'd5;
    bc.start = 1'b1;
    @(posedge clk); #1;
    bc.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("in_mul2", 32'(w_outs), 32'(exp_tab[3]));
    rst = 1'b0;
    #1;
    chk("rst_mid_outs", 32'(w_outs), 32'd0);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    run_eval(16'd0, 16'd0, 16'd7, 16'd9, res, lat);
    chk("after_rst_result", 32'(res), 32'd7);
    chk("after_rst_latency", 32'(lat), 32'd6);

    // 16-bit wrap
    run_eval(16'h0100, 16'h0000, 16'h0001, 16'h0100, res, lat);
    chk("wrap_result", 32'(res), 32'h0001);
    chk("wrap_latency", 32'(lat), 32'd6);

`ifdef BC_CONTA_AVALIACOES_EN
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("cnt_reset", 32'(bc.contagem), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    a = 16'd1; b = 16'd0; c = 16'd1; xis = 16'd3;
    bc.start = 1'b1;
    npr = 0;
    for (int i = 0; i < 1799; i++) begin
      @(posedge clk); #1;
      if (bc.pronto) npr++;
    end
    bc.start = 1'b0;
    chk("cnt_pulses", 32'(npr), 32'd257);
    chk("cnt_wrap", 32'(bc.contagem), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
